// File: rtl/cdc_src_arbiter_pkg.sv
// Shared types and helpers for the CDC source arbiter.
// The optional stall watchdog is selected with CDC_SRC_ARBITER_STALL_WDOG_EN.
package cdc_arb_pkg;

    typedef logic [63:0] T;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

    localparam int DEFAULT_STALL_LIMIT = 1024;

    // Requester tag width: at least one bit even for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdc_src_arbiter_if.sv
// Requester and CDC-source handshake bundle for cdc_src_arbiter.
// The arbiter connects through the slave modport; the driving side uses master.
interface cdc_src_arbiter_if
    import cdc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ*64-1:0] req_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    T                      out_data_o;
    logic [ID_W-1:0]       out_id_o;

    modport slave (
        input  req_valid_i, req_data_i, out_ready_i,
        output req_ready_o, out_valid_o, out_data_o, out_id_o
    );

    modport master (
        output req_valid_i, req_data_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_data_o, out_id_o
    );
endinterface

// File: rtl/cdc_src_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_i, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic [ID_W-1:0] cand;

    // Scan last_i+1 .. last_i+NUM_REQ (mod NUM_REQ) and keep the first hit.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_i) + k) % NUM_REQ);
            if (!any_o && valid_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdc_src_arbiter.sv
// Round-robin arbiter sharing one CDC source valid/ready port among NUM_REQ
// requesters through a single registered output slot.
// Optional stall watchdog: define CDC_SRC_ARBITER_STALL_WDOG_EN.
module cdc_src_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = id_width(NUM_REQ),
    parameter int STALL_LIMIT = DEFAULT_STALL_LIMIT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    cdc_src_arbiter_if.slave        bus,
    output logic                    stall_err_o
);

    slot_state_e        state_q, state_d;
    logic [ID_W-1:0]    last_q;
    T                   data_q;
    logic [ID_W-1:0]    id_q;
    logic               slot_valid;

    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic               any_valid;
    logic               slot_free;
    logic               take;
    T                   req_words [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid_i (bus.req_valid_i),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (any_valid)
    );

    // Unpack the flat payload bus into per-requester words.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_words[i] = bus.req_data_i[64*i +: 64];
        end
    end

    // A grant happens only when the slot empties this cycle and nobody is in reset.
    assign slot_free       = !slot_valid || bus.out_ready_i;
    assign take            = slot_free && any_valid && !rst_i;
    assign bus.req_ready_o = take ? pick_grant : '0;

    // Slot state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_EMPTY;
        else       state_q <= state_d;
    end

    // Slot next state: a grant always refills; a consumed word without refill empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (take) state_d = S_FULL;
            S_FULL:  if (bus.out_ready_i && !take) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    // Slot outputs decoded from state.
    always_comb begin
        slot_valid = (state_q == S_FULL);
    end

    // Capture the granted word, its tag and advance the rotation pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            id_q   <= '0;
            last_q <= ID_W'(NUM_REQ - 1);
        end else if (take) begin
            data_q <= req_words[pick_idx];
            id_q   <= pick_idx;
            last_q <= pick_idx;
        end
    end

    assign bus.out_valid_o = slot_valid;
    assign bus.out_data_o  = data_q;
    assign bus.out_id_o    = id_q;

`ifdef CDC_SRC_ARBITER_STALL_WDOG_EN
    localparam logic [15:0] LIMIT_C = 16'(STALL_LIMIT);

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_err_q, stall_err_d;

    // Count consecutive stalled cycles, saturating; flag sticks once the limit is hit.
    always_comb begin
        stall_cnt_d = '0;
        if (slot_valid && !bus.out_ready_i) begin
            stall_cnt_d = (stall_cnt_q == LIMIT_C) ? stall_cnt_q : stall_cnt_q + 16'd1;
        end
        stall_err_d = stall_err_q | (stall_cnt_q == LIMIT_C);
    end

    // Watchdog registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign stall_err_o = stall_err_q;
`else
    assign stall_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_src_arbiter.sv
module tb_cdc_src_arbiter;
    import cdc_arb_pkg::*;

    localparam int N = 4;
`ifdef CDC_SRC_ARBITER_STALL_WDOG_EN
    localparam int LIM    = 8;
    localparam bit WDOG_ON = 1'b1;
`else
    localparam int LIM    = 1024;
    localparam bit WDOG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic stall_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cdc_src_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus ();

    cdc_src_arbiter #(
        .NUM_REQ     (N),
        .ID_W        (2),
        .STALL_LIMIT (LIM)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .stall_err_o (stall_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_word(input int i, input logic [63:0] w);
        bus.req_data_i[64*i +: 64] = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    bit          m_init = 1'b0;
    bit          m_valid;
    logic [63:0] m_data;
    int          m_id;
    int          m_last;
    int          m_stall;
    bit          m_err;

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        bit           free;
        int           g;
        bit           stalled;
        if (m_init) begin
            chk("m_out_valid", {63'd0, bus.out_valid_o}, {63'd0, m_valid});
            chk("m_out_data", bus.out_data_o, m_data);
            chk("m_out_id", {62'd0, bus.out_id_o}, 64'(m_id));
            chk("m_stall_err", {63'd0, stall_err}, {63'd0, m_err});
        end
        exp_rdy = '0;
        if (rst) begin
            chk("m_rdy_in_rst", {60'd0, bus.req_ready_o}, 64'd0);
            m_init = 1'b1; m_valid = 1'b0; m_data = '0; m_id = 0;
            m_last = N - 1; m_stall = 0; m_err = 1'b0;
        end else if (m_init) begin
            free = !m_valid || bus.out_ready_i;
            g = -1;
            if (free) begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && bus.req_valid_i[(m_last + k) % N]) g = (m_last + k) % N;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("m_req_ready", {60'd0, bus.req_ready_o}, {60'd0, exp_rdy});
            stalled = m_valid && !bus.out_ready_i;
            if (WDOG_ON) begin
                if (m_stall >= LIM) m_err = 1'b1;
                m_stall = stalled ? ((m_stall >= LIM) ? LIM : m_stall + 1) : 0;
            end
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = bus.req_data_i[64*g +: 64];
                m_id    = g;
                m_last  = g;
            end else if (free) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- stimulus and literal pins ----------------
    int cnt [N];

    initial begin
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.out_ready_i = 1'b1;
        rst = 1'b1;

        // reset then idle
        tick(); tick();
        chk("rst_out_valid", {63'd0, bus.out_valid_o}, 64'd0);
        chk("rst_out_id", {62'd0, bus.out_id_o}, 64'd0);
        chk("rst_out_data", bus.out_data_o, 64'd0);
        chk("rst_req_ready", {60'd0, bus.req_ready_o}, 64'd0);
        chk("rst_stall_err", {63'd0, stall_err}, 64'd0);
        rst = 1'b0;
        #1 chk("idle_req_ready", {60'd0, bus.req_ready_o}, 64'd0);
        tick();
        chk("idle_out_valid", {63'd0, bus.out_valid_o}, 64'd0);

        // single requester streaming back-to-back
        for (int i = 0; i < 3; i++) begin
            set_word(2, 64'h10 + 64'(i));
            bus.req_valid_i = 4'b0100;
            #1 chk("stream_ready", {60'd0, bus.req_ready_o}, 64'b0100);
            tick();
            chk("stream_valid", {63'd0, bus.out_valid_o}, 64'd1);
            chk("stream_data", bus.out_data_o, 64'h10 + 64'(i));
            chk("stream_id", {62'd0, bus.out_id_o}, 64'd2);
        end
        bus.req_valid_i = '0;
        tick();
        chk("stream_drain", {63'd0, bus.out_valid_o}, 64'd0);

        // fairness from a fresh reset
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        bus.req_valid_i = 4'b1111;
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < N; r++) set_word(r, {32'(r), 32'(i)});
            tick();
            if (i < 6) chk("fair_order", {62'd0, bus.out_id_o}, 64'(i % N));
            cnt[bus.out_id_o]++;
        end
        for (int i = 0; i < N; i++) chk("fair_share", 64'(cnt[i]), 64'd10);

        // backpressure: hold 0xAA from id 1 while req 3 waits
        bus.req_valid_i = 4'b0010; set_word(1, 64'hAA);
        tick();
        bus.req_valid_i = 4'b1000; set_word(3, 64'hBB);
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_ready", {60'd0, bus.req_ready_o}, 64'd0);
            tick();
            chk("bp_data_hold", bus.out_data_o, 64'hAA);
            chk("bp_id_hold", {62'd0, bus.out_id_o}, 64'd1);
        end
        bus.out_ready_i = 1'b1;
        #1 chk("bp_release_ready", {60'd0, bus.req_ready_o}, 64'b1000);
        tick();
        chk("bp_new_data", bus.out_data_o, 64'hBB);
        chk("bp_new_id", {62'd0, bus.out_id_o}, 64'd3);

        // mid-operation reset with the slot full
        bus.out_ready_i = 1'b0;
        bus.req_valid_i = 4'b0001; set_word(0, 64'hCC);
        rst = 1'b1;
        #1 chk("mrst_ready", {60'd0, bus.req_ready_o}, 64'd0);
        tick();
        chk("mrst_valid", {63'd0, bus.out_valid_o}, 64'd0);
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        bus.req_valid_i = 4'b1111;
        #1 chk("mrst_first_grant", {60'd0, bus.req_ready_o}, 64'b0001);
        tick();
        chk("mrst_first_id", {62'd0, bus.out_id_o}, 64'd0);

        // watchdog: long stall, then release
        bus.req_valid_i = 4'b0100;
        tick();
        bus.req_valid_i = '0;
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        bus.out_ready_i = 1'b1;
        tick(); tick();
        chk("wdog_flag", {63'd0, stall_err}, {63'd0, WDOG_ON});

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.req_valid_i = 4'($urandom);
            for (int r = 0; r < N; r++) set_word(r, {$urandom, $urandom});
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        bus.req_valid_i = '0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
